// File: rtl/dmux_router_if.sv
// Handshake bundle for dmux_router: one upstream source port and CH downstream sink channels.
// The source/sink testbench or wrapper takes the master view, and the router takes the slave view.
interface dmux_router_if #(
   parameter int WIDTH    = 1,
   parameter int SEL_BITS = 3
);
   localparam int CH = 2 ** SEL_BITS;

   logic [WIDTH-1:0]    in_data;
   logic [SEL_BITS-1:0] in_sel;
   logic                in_bcast;
   logic                in_valid;
   logic                in_ready;
   logic [CH*WIDTH-1:0] out_data;
   logic [CH-1:0]       out_valid;
   logic [CH-1:0]       out_ready;

   modport master (
      output in_data, in_sel, in_bcast, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_bcast, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/dmux_router.sv
// Registered 1-to-CH demultiplexer with unicast/broadcast routing and one skid-free slot per channel.
// A slot may be drained and reloaded in the same cycle, so every channel sustains one word per cycle.
module dmux_router #(
   parameter int WIDTH    = 1,
   parameter int SEL_BITS = 3
) (
   input logic          clock,
   input logic          reset,
   dmux_router_if.slave bus
);
   localparam int CH = 2 ** SEL_BITS;

   logic [CH*WIDTH-1:0] data_r;
   logic [CH-1:0]       valid_r;
   logic [CH-1:0]       free_s;
   logic [CH-1:0]       load_s;
   logic                ready_s;
   logic                accept_s;

   // A slot is free when it is empty or its sink takes the held word this cycle.
   always_comb begin
      free_s = ~valid_r | bus.out_ready;
   end

   // Ready depends only on slot state and routing, never on in_valid or in_data.
   always_comb begin
      ready_s = 1'b0;
      if (reset) begin
         ready_s = 1'b0;
      end else if (bus.in_bcast) begin
         ready_s = &free_s;
      end else begin
         ready_s = free_s[bus.in_sel];
      end
   end

   // Per-slot load strobes for the accepted word.
   always_comb begin
      accept_s = bus.in_valid & ready_s;
      load_s   = {CH{1'b0}};
      for (int i = 0; i < CH; i++) begin
         load_s[i] = accept_s & (bus.in_bcast | (bus.in_sel == SEL_BITS'(i)));
      end
   end

   // Slot registers: load wins over drain; an undrained slot holds its word.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_r  <= {(CH*WIDTH){1'b0}};
         valid_r <= {CH{1'b0}};
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (load_s[i]) begin
               data_r[i*WIDTH +: WIDTH] <= bus.in_data;
               valid_r[i]               <= 1'b1;
            end else if (bus.out_ready[i]) begin
               valid_r[i] <= 1'b0;
            end else begin
               valid_r[i] <= valid_r[i];
            end
         end
      end
   end

   assign bus.in_ready  = ready_s;
   assign bus.out_data  = data_r;
   assign bus.out_valid = valid_r;
endmodule

// File: tb/tb_dmux_router.sv
// Directed self-checking bench for dmux_router at WIDTH=8, SEL_BITS=3.
module tb_dmux_router;
   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   dmux_router_if #(.WIDTH(8), .SEL_BITS(3)) bus ();

   dmux_router #(.WIDTH(8), .SEL_BITS(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] chan(input logic [63:0] d, input int i);
      return d[i*8 +: 8];
   endfunction

   initial begin
      // Reset with a word offered: nothing accepted, everything cleared
      reset = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h77;
      bus.in_sel    = 3'd2;
      bus.in_bcast  = 1'b0;
      bus.out_ready = 8'h00;
      #1;
      chk("rst_ready_pre", 64'(bus.in_ready), 64'd0);
      tick();
      chk("rst_valid", 64'(bus.out_valid), 64'h00);
      chk("rst_data", bus.out_data, 64'h0);
      chk("rst_ready", 64'(bus.in_ready), 64'd0);

      // Sweep unicast over all channels, first accept right after reset
      reset = 1'b0;
      bus.out_ready = 8'hFF;
      for (int s = 0; s < 8; s++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = 3'(s);
         bus.in_data  = 8'h10 + 8'(s);
         #1;
         chk("sweep_ready", 64'(bus.in_ready), 64'd1);
         tick();
         chk("sweep_valid", 64'(bus.out_valid), 64'(8'h01 << s));
         chk("sweep_data", 64'(chan(bus.out_data, s)), 64'(8'h10 + 8'(s)));
      end
      bus.in_valid = 1'b0;
      tick();
      chk("sweep_drain", 64'(bus.out_valid), 64'h00);

      // Backpressure on channel 3
      bus.out_ready = 8'hF7;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 3'd3;
      bus.in_data   = 8'hA5;
      tick();
      chk("bp_first", 64'(chan(bus.out_data, 3)), 64'hA5);
      bus.in_data = 8'h5A;
      #1;
      chk("bp_stall_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("bp_hold_data", 64'(chan(bus.out_data, 3)), 64'hA5);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'h08);
      bus.out_ready = 8'hFF;
      #1;
      chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk("bp_second", 64'(chan(bus.out_data, 3)), 64'h5A);
      chk("bp_second_valid", 64'(bus.out_valid), 64'h08);
      bus.in_valid = 1'b0;
      tick();
      chk("bp_drain", 64'(bus.out_valid), 64'h00);

      // Broadcast blocked by a full channel 6
      bus.out_ready = 8'hBF;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 3'd6;
      bus.in_data   = 8'h66;
      tick();
      chk("bc_fill", 64'(bus.out_valid), 64'h40);
      bus.in_bcast = 1'b1;
      bus.in_data  = 8'hFF;
      #1;
      chk("bc_blocked", 64'(bus.in_ready), 64'd0);
      tick();
      chk("bc_hold", 64'(chan(bus.out_data, 6)), 64'h66);
      chk("bc_hold_valid", 64'(bus.out_valid), 64'h40);
      bus.out_ready = 8'hFF;
      #1;
      chk("bc_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk("bc_valid", 64'(bus.out_valid), 64'hFF);
      chk("bc_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      bus.in_valid = 1'b0;
      bus.in_bcast = 1'b0;
      tick();
      chk("bc_drain", 64'(bus.out_valid), 64'h00);

      // Back-to-back streaming into channel 2
      bus.in_valid = 1'b1;
      bus.in_sel   = 3'd2;
      for (int k = 1; k <= 3; k++) begin
         bus.in_data = 8'(k);
         tick();
         chk("st_valid", 64'(bus.out_valid), 64'h04);
         chk("st_data", 64'(chan(bus.out_data, 2)), 64'(k));
      end
      bus.in_valid = 1'b0;
      tick();
      chk("st_end", 64'(bus.out_valid), 64'h00);
      chk("st_keep_data", 64'(chan(bus.out_data, 2)), 64'h03);

      // Reset mid-operation discards held words and the offered word
      bus.out_ready = 8'h00;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 3'd1; bus.in_data = 8'h11; tick();
      bus.in_sel    = 3'd4; bus.in_data = 8'h44; tick();
      bus.in_sel    = 3'd7; bus.in_data = 8'h77; tick();
      chk("mr_loaded", 64'(bus.out_valid), 64'h92);
      reset = 1'b1;
      bus.in_sel  = 3'd0;
      bus.in_data = 8'hAB;
      #1;
      chk("mr_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("mr_valid", 64'(bus.out_valid), 64'h00);
      chk("mr_data", bus.out_data, 64'h0);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      chk("mr_nothing", 64'(bus.out_valid), 64'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
